// File: rtl/matrix_framer.sv
// Buffers ROW*COL words and releases them as one contiguous out_valid burst per matrix.
// Optional completed-burst counter on port frames when MATRIX_FRAMER_FRAMES_EN is defined.
module matrix_framer #(
    parameter int ROW   = 5,
    parameter int COL   = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
`ifdef MATRIX_FRAMER_FRAMES_EN
    ,
    output logic [15:0]      frames
`endif
);

    localparam int N  = ROW * COL;
    localparam int CW = $clog2(N + 1);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] FULL = CW'(N);
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_BURST = 1'b1;

    logic             r_state;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [PW-1:0]    r_burstCnt;
    logic [WIDTH-1:0] r_mem [N];

    logic w_push;
    logic w_pop;
    logic w_start;
    logic w_end;

    assign in_ready = (r_count < FULL);
    assign w_push   = in_valid && in_ready;
    assign w_start  = (r_state == S_IDLE) && (r_count == FULL);
    assign w_end    = (r_state == S_BURST) && (r_burstCnt == LAST);
    // The edge after the last burst word pops nothing; it is the mandatory low gap.
    assign w_pop    = w_start || ((r_state == S_BURST) && !w_end);

    // Storage is left unreset; stale contents are never read because pointers and count reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_burstCnt <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= (r_wrPtr == LAST) ? '0 : r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == LAST) ? '0 : r_rdPtr + PW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_start) begin
                r_state    <= S_BURST;
                out_valid  <= 1'b1;
                out_data   <= r_mem[r_rdPtr];
                r_burstCnt <= '0;
            end else if (w_end) begin
                r_state   <= S_IDLE;
                out_valid <= 1'b0;
            end else if (r_state == S_BURST) begin
                out_data   <= r_mem[r_rdPtr];
                r_burstCnt <= r_burstCnt + PW'(1);
            end
        end
    end

`ifdef MATRIX_FRAMER_FRAMES_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frames <= '0;
        end else if (w_end) begin
            frames <= frames + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_framer.sv
// Randomised and directed bench for matrix_framer, checked each cycle against a
// queue-based behavioural model of the matrix bursts.
module tb_matrix_framer;

    localparam int ROW   = 5;
    localparam int COL   = 4;
    localparam int WIDTH = 16;
    localparam int N     = ROW * COL;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
`ifdef MATRIX_FRAMER_FRAMES_EN
    logic [15:0]      frames;
`endif

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mdlQ [$];
    int               mdlEmitLeft;
    logic             mdlOutValid;
    logic [WIDTH-1:0] mdlOutData;
    int               mdlFrames;

    matrix_framer #(.ROW(ROW), .COL(COL), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
`ifdef MATRIX_FRAMER_FRAMES_EN
        ,
        .frames    (frames)
`endif
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mdlQ.delete();
        mdlEmitLeft = 0;
        mdlOutValid = 1'b0;
        mdlOutData  = '0;
        mdlFrames   = 0;
    endtask

    task automatic checkOutput();
        checks++;
        assert (in_ready === (mdlQ.size() < N)) else begin
            errors++;
            $error("[TB] FAIL in_ready got %b want %b", in_ready, (mdlQ.size() < N));
        end
        checks++;
        assert (out_valid === mdlOutValid) else begin
            errors++;
            $error("[TB] FAIL out_valid got %b want %b", out_valid, mdlOutValid);
        end
        checks++;
        assert (out_data === mdlOutData) else begin
            errors++;
            $error("[TB] FAIL out_data got %h want %h", out_data, mdlOutData);
        end
`ifdef MATRIX_FRAMER_FRAMES_EN
        checks++;
        assert (frames === 16'(mdlFrames)) else begin
            errors++;
            $error("[TB] FAIL frames got %0d want %0d", frames, mdlFrames);
        end
`endif
    endtask

    // One clock: check the settled outputs, drive the next inputs, advance the model across the edge.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic rstn,
                                 output logic accepted);
        logic push;
        @(negedge clk);
        checkOutput();
        in_valid = v;
        in_data  = d;
        rst_n    = rstn;
        push     = v && (mdlQ.size() < N);
        accepted = rstn && push;
        if (!rstn) begin
            modelReset();
        end else begin
            if (mdlEmitLeft > 0) begin
                mdlOutData = mdlQ.pop_front();
                mdlEmitLeft--;
            end else if (mdlOutValid) begin
                mdlOutValid = 1'b0;
                mdlFrames   = (mdlFrames + 1) % 65536;
            end else if (mdlQ.size() == N) begin
                mdlOutValid = 1'b1;
                mdlOutData  = mdlQ.pop_front();
                mdlEmitLeft = N - 1;
            end
            if (push) mdlQ.push_back(d);
        end
    endtask

    initial begin
        logic             acc;
        logic [WIDTH-1:0] nextWord;
        int               pushed;
        int               guard;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        modelReset();
        repeat (2) @(posedge clk);

        // Reset with in_valid high: nothing may be stored.
        applyStimulus(1'b1, 16'hDEAD, 1'b0, acc);
        applyStimulus(1'b0, '0, 1'b1, acc);

        // Sequential matrix 0x0000..0x0013.
        for (int i = 0; i < N; i++) applyStimulus(1'b1, WIDTH'(i), 1'b1, acc);
        repeat (25) applyStimulus(1'b0, '0, 1'b1, acc);

        // 40 words with in_valid held high; data advances only when accepted.
        nextWord = 16'h0100;
        pushed   = 0;
        guard    = 0;
        while (pushed < 2 * N && guard < 200) begin
            applyStimulus(1'b1, nextWord, 1'b1, acc);
            if (acc) begin
                pushed++;
                nextWord++;
            end
            guard++;
        end
        checks++;
        assert (pushed == 2 * N) else begin
            errors++;
            $error("[TB] FAIL backpressure_push got %0d want %0d", pushed, 2 * N);
        end
        repeat (50) applyStimulus(1'b0, '0, 1'b1, acc);

        // Partial matrix waits, then the final word releases it.
        for (int i = 0; i < N - 1; i++) applyStimulus(1'b1, 16'h0200 + WIDTH'(i), 1'b1, acc);
        repeat (100) applyStimulus(1'b0, '0, 1'b1, acc);
        applyStimulus(1'b1, 16'h0213, 1'b1, acc);
        repeat (30) applyStimulus(1'b0, '0, 1'b1, acc);

        // Reset while burst word 7 is on out_data, then a fresh matrix.
        for (int i = 0; i < N; i++) applyStimulus(1'b1, 16'h0300 + WIDTH'(i), 1'b1, acc);
        guard = 0;
        while (!(mdlOutValid && (N - 1 - mdlEmitLeft) == 7) && guard < 40) begin
            applyStimulus(1'b0, '0, 1'b1, acc);
            guard++;
        end
        checks++;
        assert (guard < 40) else begin
            errors++;
            $error("[TB] FAIL reach_word7 got %0d want <40", guard);
        end
        applyStimulus(1'b0, '0, 1'b0, acc);
        for (int i = 0; i < N; i++) applyStimulus(1'b1, 16'h0400 + WIDTH'(i), 1'b1, acc);
        repeat (30) applyStimulus(1'b0, '0, 1'b1, acc);

        // Random 50% traffic overlapping bursts.
        for (int i = 0; i < N; i++) applyStimulus(1'b1, WIDTH'($urandom), 1'b1, acc);
        repeat (400) applyStimulus(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'b1, acc);
        repeat (60) applyStimulus(1'b0, '0, 1'b1, acc);

        @(negedge clk);
        checkOutput();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_framer.md
MATRIX_FRAMER -- requirements
Module: matrix_framer

Interface
REQ-001 Parameter ROW, default 5: matrix rows; SHALL match the downstream matrix loader.
REQ-002 Parameter COL, default 4: matrix columns; SHALL match the downstream matrix loader.
REQ-003 Parameter WIDTH, default 16: data word width in bits.
REQ-004 Port clk  input  1: single clock; all state SHALL update on its rising edge only.
REQ-005 Port rst_n  input  1: synchronous, active-low reset, sampled on rising clk.
REQ-006 Port in_valid  input  1: upstream word offered.
REQ-007 Port in_data  input  WIDTH: upstream word.
REQ-008 Port in_ready  output  1: block can accept a word this cycle.
REQ-009 Port out_valid  output  1: drives the loader's valid; SHALL be high only during a contiguous matrix burst.
REQ-010 Port out_data  output  WIDTH: drives the loader's data.
REQ-011 Port frames  output  16: completed-burst count; present only under REQ-030.

Function
REQ-012 N = ROW*COL; internal FIFO depth SHALL be exactly N words of WIDTH bits; pointers SHALL wrap modulo N; count width SHALL be clog2(N+1).
REQ-013 in_ready SHALL be combinational: in_ready = (count < N), using the registered count.
REQ-014 A word SHALL be written on each rising edge where in_valid && in_ready; in_data is ignored otherwise.
REQ-015 FSM states: IDLE, BURST; reset state is IDLE.
REQ-016 IDLE -> BURST on an edge where count == N; on that same edge out_valid <= 1, out_data <= FIFO head, and the head is popped.
REQ-017 Latency: out_valid SHALL rise on the first edge after the edge that writes the N-th word.
REQ-018 In BURST, every edge SHALL pop one word to out_data with out_valid held at 1, with no bubbles, until exactly N words have been emitted.
REQ-019 On the edge after the N-th output word, out_valid SHALL go 0 and the FSM SHALL return to IDLE, giving a minimum one-cycle low gap between bursts so the loader's row and column counters rewind.
REQ-020 out_data SHALL hold its last value while out_valid is 0.
REQ-021 Word order SHALL be strict FIFO: burst word k is the k-th word accepted for that matrix, in row-major order.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; a write into the slot freed by the same-edge pop is legal.
REQ-023 Burst word counter: clog2(N) bits; it SHALL clear on IDLE -> BURST and SHALL never exceed N-1.
REQ-024 Writes are blocked only when count == N; a push accepted during a burst is stored for the next matrix.
REQ-025 Fewer than N buffered words SHALL never start a burst; partial matrices wait indefinitely.

Reset
REQ-026 While rst_n == 0 at an edge: state = IDLE, count = 0, read/write pointers = 0, burst counter = 0, out_valid = 0, out_data = 0, frames = 0.
REQ-027 in_ready SHALL be 1 during and after reset, since count = 0.
REQ-028 Reset mid-burst SHALL drop out_valid at that edge and discard all buffered words; no partial burst SHALL resume.
REQ-029 FIFO storage contents need not be reset.

Configuration
REQ-030 Macro MATRIX_FRAMER_FRAMES_EN defined: frames port exists and increments by 1, wrapping at 65535 -> 0, on the edge where out_valid falls at the end of a burst. Macro undefined: frames port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Use ROW=5, COL=4, WIDTH=16. Push 0x0000..0x0013 on 20 consecutive cycles -> out_valid high for exactly 20 cycles, starting 1 edge after the last push, with out_data 0x0000..0x0013 in order, then low.
REQ-032 Push 40 words back-to-back with in_valid held high -> in_ready drops at count 20 and recovers during the burst; two 20-word bursts are separated by at least one low out_valid cycle; no word is lost or duplicated.
REQ-033 Push 19 words and idle 100 cycles -> out_valid stays 0 and in_ready stays 1; the 20th push starts the burst on the next edge.
REQ-034 Assert rst_n = 0 at burst word 7 -> next edge out_valid = 0 and count = 0; a fresh 20 pushes then yield a correct burst starting from the new first word.
REQ-035 Pulse in_valid randomly at 50% during a burst -> burst stays contiguous for 20 cycles; the pushed words appear in order in the next burst.
REQ-036 With MATRIX_FRAMER_FRAMES_EN defined, run 3 bursts -> frames reads 3 after the third falling edge of out_valid; preload 65535 and run 1 burst -> frames reads 0.
